// File: rtl/dmem_access_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage access
// controller (master) and a variable-latency data memory (slave).
interface dmem_access_ctrl_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     mem_req;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     mem_ack;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer for the pipelined RV32 core.
// Latches the EX/MEM access, holds a req/ack transaction open until the
// memory answers (or a timeout expires), stalls the pipeline meanwhile and
// hands registered load data plus a completion pulse to MEM/WB.
module dmem_access_ctrl #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     MemWriteM,
    input  logic                     ResultSrcM,
    input  logic [ADDRESS_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0]    WriteDataM,
    dmem_access_ctrl_if.master       mem,
    output logic                     StallM,
    output logic [DATA_WIDTH-1:0]    ReadDataW,
    output logic                     MemValidW,
    output logic                     mem_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_ABORT
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     w_acc;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_we;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_err;

    // A store wins when both store and load flags are raised.
    assign w_acc = MemWriteM | ResultSrcM;

    // The request is a decode of the state register, so it is glitch-free
    // and only high while an access is outstanding.
    assign mem.mem_req   = (r_state == S_BUSY);
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign ReadDataW     = r_rdata;
    assign mem_err       = r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus stall and completion outputs.
    always_comb begin
        w_next    = r_state;
        StallM    = 1'b0;
        MemValidW = 1'b0;
        case (r_state)
            S_IDLE: begin
                StallM = w_acc;
                if (w_acc) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                StallM = 1'b1;
                if (mem.mem_ack) begin
                    w_next = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = S_ABORT;
                end
            end
            // The pipeline advances on this edge; the stale M-stage
            // instruction is deliberately not reissued.
            S_DONE: begin
                MemValidW = 1'b1;
                w_next    = S_IDLE;
            end
            S_ABORT: begin
                MemValidW = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Access latch, wait counter, load-data capture and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_cnt   <= '0;
                        r_we    <= MemWriteM;
                        r_addr  <= ALUResultM;
                        r_wdata <= WriteDataM;
                    end
                end
                S_BUSY: begin
                    if (mem.mem_ack) begin
                        if (!r_we) begin
                            r_rdata <= mem.mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ABORT: begin
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
